gate_op_pipe: RTL



---
 rtl/gate_op_pkg.sv | 14 +
 rtl/gate_op_core.sv | 30 +++
 rtl/gate_op_pipe.sv | 101 ++++++++++
 3 files changed

// File: rtl/gate_op_pkg.sv
// Shared op-code definitions for the gate_op logic unit.
// Purely declarative: no latency, no flow control.
package gate_op_pkg;
   localparam int OP_W = 3;

   localparam logic [OP_W-1:0] OP_AND  = 3'd0;
   localparam logic [OP_W-1:0] OP_OR   = 3'd1;
   localparam logic [OP_W-1:0] OP_NAND = 3'd2;
   localparam logic [OP_W-1:0] OP_NOR  = 3'd3;
   localparam logic [OP_W-1:0] OP_XOR  = 3'd4;
   localparam logic [OP_W-1:0] OP_XNOR = 3'd5;
   localparam logic [OP_W-1:0] OP_NOT  = 3'd6;
   localparam logic [OP_W-1:0] OP_MUX  = 3'd7;
endpackage

// File: rtl/gate_op_core.sv
// Bitwise logic core: one of eight ops applied to WIDTH-bit operands.
// Combinational, zero latency, no flow control.
module gate_op_core
   import gate_op_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [OP_W-1:0]  op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] s,
   output logic [WIDTH-1:0] y
);

   always_comb begin
      y = '0;
      case (op)
         OP_AND:  y = a & b;
         OP_OR:   y = a | b;
         OP_NAND: y = ~(a & b);
         OP_NOR:  y = ~(a | b);
         OP_XOR:  y = a ^ b;
         OP_XNOR: y = ~(a ^ b);
         OP_NOT:  y = ~a;
         OP_MUX:  y = (s & b) | (~s & a);
         default: y = '0;
      endcase
   end

endmodule

// File: rtl/gate_op_pipe.sv
// Two-stage registered logic unit, 2-cycle latency, 1 beat/cycle; stalls hold S2 and
// fill S1, then in_ready drops. GATE_OP_PIPE_COUNT_EN adds a saturating beat_count.
module gate_op_pipe
   import gate_op_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [OP_W-1:0]  in_op,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [WIDTH-1:0] in_s,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_y,
   output logic             out_zero,
`ifdef GATE_OP_PIPE_COUNT_EN
   output logic             out_parity,
   output logic [15:0]      beat_count
`else
   output logic             out_parity
`endif
);

   logic             s1_valid;
   logic [OP_W-1:0]  s1_op;
   logic [WIDTH-1:0] s1_a;
   logic [WIDTH-1:0] s1_b;
   logic [WIDTH-1:0] s1_s;
   logic             s2_valid;
   logic             s2_load;
   logic             s1_adv;
   logic             accept;
   logic [WIDTH-1:0] core_y;

   assign s2_load  = !s2_valid || out_ready;
   assign s1_adv   = s1_valid && s2_load;
   assign in_ready = !s1_valid || s2_load;
   assign accept   = in_valid && in_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_op    <= '0;
         s1_a     <= '0;
         s1_b     <= '0;
         s1_s     <= '0;
      end else if (accept) begin
         s1_valid <= 1'b1;
         s1_op    <= in_op;
         s1_a     <= in_a;
         s1_b     <= in_b;
         s1_s     <= in_s;
      end else if (s1_adv) begin
         s1_valid <= 1'b0;
      end
   end

   gate_op_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .op (s1_op),
      .a  (s1_a),
      .b  (s1_b),
      .s  (s1_s),
      .y  (core_y)
   );

   // Result registers keep their last value across bubbles so out_y stays deterministic.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2_valid   <= 1'b0;
         out_y      <= '0;
         out_zero   <= 1'b1;
         out_parity <= 1'b0;
      end else if (s2_load) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            out_y      <= core_y;
            out_zero   <= (core_y == '0);
            out_parity <= ^core_y;
         end
      end
   end

   assign out_valid = s2_valid;

`ifdef GATE_OP_PIPE_COUNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         beat_count <= 16'd0;
      end else if (out_valid && out_ready && (beat_count != 16'hFFFF)) begin
         beat_count <= beat_count + 16'd1;
      end
   end
`endif

endmodule
